vehicle_level_controller: RTL and testbench

Drives the vehicle-lane pattern generator: produces the 2-bit difficulty level (NV) and the one-cycle lane-shift strobe (CN) that the lane registers consume. It runs the game-progress state machine: start, level advance on frog goal, end on crash or final goal. It sits between the game-event logic (frog/collision detection) and the lane-pattern block.

---
 rtl/vehicle_level_controller_pkg.sv | 19 +
 rtl/vehicle_tick_divider.sv | 36 +++
 rtl/vehicle_level_controller.sv | 105 ++++++++++
 tb/tb_vehicle_level_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vehicle_level_controller_pkg.sv
// Shared definitions for the vehicle-lane level controller: FSM encodings,
// top level number and the per-level shift period.
package vehicle_level_controller_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StAdvance = 2'd2,
    StOver    = 2'd3
  } state_e;

  localparam int unsigned LEVEL_MAX = 3;

  // Each level halves the shift period.
  function automatic int unsigned shift_period(input int unsigned base, input int unsigned lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/vehicle_tick_divider.sv
// Down-counter producing a one-cycle tick every period_i enabled cycles.
module vehicle_tick_divider #(
  parameter int unsigned DATAWIDTH_DIV = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     en_i,
  input  logic [DATAWIDTH_DIV-1:0] period_i,
  output logic                     tick_o
);

  logic [DATAWIDTH_DIV-1:0] cnt_q, cnt_d;
  logic                     zero;

  assign zero   = (cnt_q == '0);
  assign tick_o = en_i & ~load_i & zero;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = period_i - DATAWIDTH_DIV'(1);
    end else if (en_i) begin
      cnt_d = zero ? (period_i - DATAWIDTH_DIV'(1)) : (cnt_q - DATAWIDTH_DIV'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vehicle_level_controller.sv
// Game-progress FSM driving the lane pattern block: difficulty level (NV)
// and registered lane-shift strobe (CN).
module vehicle_level_controller
  import vehicle_level_controller_pkg::*;
#(
  parameter int unsigned DATAWIDTH_NVL = 2,
  parameter int unsigned DATAWIDTH_DIV = 24,
  parameter int unsigned BASE_DIV      = 12500000
) (
  input  logic                     CNV_CLOCK,
  input  logic                     CNV_RESET,
  input  logic                     CNV_START_IN,
  input  logic                     CNV_GOAL_IN,
  input  logic                     CNV_CRASH_IN,
  input  logic                     CNV_PAUSE_IN,
  output logic [DATAWIDTH_NVL-1:0] CNV_NV_OUT,
  output logic                     CNV_CN_OUT,
  output logic [1:0]               CNV_STATE_OUT,
  output logic                     CNV_WIN_OUT
);

  state_e                   state_q, state_d;
  logic [DATAWIDTH_NVL-1:0] level_q, level_d;
  logic                     cn_q, cn_d;
  logic                     win_q, win_d;
  logic                     div_load, div_en, div_tick;
  logic [DATAWIDTH_DIV-1:0] div_period;

  // Period follows the next-state level so loads on START/GOAL use the new level.
  assign div_period = DATAWIDTH_DIV'(shift_period(BASE_DIV, 32'(level_d)));

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    win_d    = win_q;
    cn_d     = 1'b0;
    div_load = 1'b0;
    div_en   = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (CNV_START_IN) begin
          state_d  = StRun;
          level_d  = '0;
          win_d    = 1'b0;
          div_load = 1'b1;
        end
      end
      StRun: begin
        if (CNV_CRASH_IN) begin
          state_d = StOver;
          win_d   = 1'b0;
        end else if (CNV_GOAL_IN) begin
          if (level_q == DATAWIDTH_NVL'(LEVEL_MAX)) begin
            state_d = StOver;
            win_d   = 1'b1;
          end else begin
            state_d  = StAdvance;
            level_d  = level_q + DATAWIDTH_NVL'(1);
            div_load = 1'b1;
          end
        end else if (!CNV_PAUSE_IN) begin
          div_en = 1'b1;
          cn_d   = div_tick;
        end
      end
      StAdvance: begin
        // Reload again so the first period at the new level starts on return to RUN.
        state_d  = StRun;
        div_load = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CNV_CLOCK or negedge CNV_RESET) begin
    if (!CNV_RESET) begin
      state_q <= StIdle;
      level_q <= '0;
      cn_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cn_q    <= cn_d;
      win_q   <= win_d;
    end
  end

  vehicle_tick_divider #(
    .DATAWIDTH_DIV(DATAWIDTH_DIV)
  ) u_tick_divider (
    .clk_i   (CNV_CLOCK),
    .rst_ni  (CNV_RESET),
    .load_i  (div_load),
    .en_i    (div_en),
    .period_i(div_period),
    .tick_o  (div_tick)
  );

  assign CNV_NV_OUT    = level_q;
  assign CNV_CN_OUT    = cn_q;
  assign CNV_STATE_OUT = state_q;
  assign CNV_WIN_OUT   = win_q;

endmodule

// File: tb/tb_vehicle_level_controller.sv
// Directed bench for vehicle_level_controller with BASE_DIV=16; expected strobe
// edges are queued as stimulus is driven and matched against CN every cycle.
module tb_vehicle_level_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, goal = 1'b0, crash = 1'b0, pause = 1'b0;
  logic [1:0] nv;
  logic       cn;
  logic [1:0] st;
  logic       win;

  int n_chk = 0;
  int n_pass = 0;
  int e = -100;
  int exp_q[$];

  always #5 clk = ~clk;

  vehicle_level_controller #(
    .DATAWIDTH_NVL(2),
    .DATAWIDTH_DIV(24),
    .BASE_DIV     (16)
  ) dut (
    .CNV_CLOCK    (clk),
    .CNV_RESET    (rst_n),
    .CNV_START_IN (start),
    .CNV_GOAL_IN  (goal),
    .CNV_CRASH_IN (crash),
    .CNV_PAUSE_IN (pause),
    .CNV_NV_OUT   (nv),
    .CNV_CN_OUT   (cn),
    .CNV_STATE_OUT(st),
    .CNV_WIN_OUT  (win)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic check_outs(input string tag, input int s, input int l, input int w);
    check({tag, ".state"}, 32'(st), s);
    check({tag, ".nv"}, 32'(nv), l);
    check({tag, ".win"}, 32'(win), w);
  endtask

  // Advance one edge, sample 1 time unit later, and score CN against the queue.
  task automatic step();
    logic exp_cn;
    @(posedge clk);
    #1;
    e++;
    exp_cn = (exp_q.size() > 0 && exp_q[0] == e);
    check($sformatf("cn@%0d", e), 32'(cn), 32'(exp_cn));
    if (exp_cn) void'(exp_q.pop_front());
  endtask

  task automatic run_to(input int last);
    while (e < last) step();
  endtask

  task automatic start_game();
    e = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("start", 1, 0, 0);
  endtask

  task automatic goal_at(input int g);
    run_to(g - 1);
    goal = 1'b1;
    step();
    goal = 1'b0;
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 0, 0, 0);
    check("rst_async.cn", 32'(cn), 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held while inputs toggle.
    #2;
    check_outs("por", 0, 0, 0);
    check("por.cn", 32'(cn), 0);
    for (int i = 0; i < 4; i++) begin
      {start, goal, crash, pause} = 4'($urandom_range(1, 15));
      step();
      check_outs("rst_held", 0, 0, 0);
    end
    {start, goal, crash, pause} = 4'b0;
    rst_n = 1'b1;
    step();
    step();
    check_outs("rst_release", 0, 0, 0);

    // Level 0 free run: strobes at 16, 32, 48.
    start_game();
    exp_q.push_back(16);
    exp_q.push_back(32);
    exp_q.push_back(48);
    run_to(50);
    check_outs("run0", 1, 0, 0);
    check("run0.drained", exp_q.size(), 0);

    // Goal at 20: one ADVANCE cycle, level 1 strobes at 29, 37, 45.
    do_reset();
    start_game();
    exp_q.push_back(16);
    goal_at(20);
    check_outs("adv20", 2, 1, 0);
    exp_q.push_back(29);
    exp_q.push_back(37);
    exp_q.push_back(45);
    step();
    check_outs("adv20.back", 1, 1, 0);
    run_to(47);
    check("adv.drained", exp_q.size(), 0);

    // Pause over edges 40..44 shifts the 48 strobe to 53.
    do_reset();
    start_game();
    exp_q.push_back(16);
    exp_q.push_back(32);
    exp_q.push_back(53);
    exp_q.push_back(69);
    run_to(39);
    pause = 1'b1;
    run_to(44);
    pause = 1'b0;
    run_to(72);
    check("pause.drained", exp_q.size(), 0);

    // Crash with goal at level 1 -> lose; strobe due at 14 must not appear.
    do_reset();
    start_game();
    goal_at(5);
    check_outs("g5", 2, 1, 0);
    run_to(9);
    crash = 1'b1;
    goal = 1'b1;
    step();
    crash = 1'b0;
    goal = 1'b0;
    check_outs("crash10", 3, 1, 0);
    run_to(14);
    check_outs("over_hold", 3, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("restart15", 1, 0, 0);
    goal_at(17);
    check_outs("g17", 2, 1, 0);
    goal_at(20);
    check_outs("g20", 2, 2, 0);
    goal_at(23);
    check_outs("g23", 2, 3, 0);
    exp_q.push_back(26);
    exp_q.push_back(28);
    exp_q.push_back(30);
    goal_at(31);
    check_outs("win31", 3, 3, 1);
    run_to(33);
    check_outs("win_hold", 3, 3, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("restart34", 1, 0, 0);
    exp_q.push_back(50);
    run_to(51);

    // Mid-run asynchronous reset at level 2, then clean restart.
    do_reset();
    start_game();
    goal_at(3);
    goal_at(6);
    check_outs("g6", 2, 2, 0);
    exp_q.push_back(11);
    exp_q.push_back(15);
    exp_q.push_back(19);
    run_to(20);
    check_outs("lvl2", 1, 2, 0);
    #2;
    do_reset();
    check_outs("post_rst", 0, 0, 0);
    start_game();
    exp_q.push_back(16);
    run_to(17);
    check_outs("final", 1, 0, 0);
    check("final.drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
